// File: rtl/wide_add_sequencer.sv
// Sequences a 4*NIBBLES-bit addition through an external registered 4-bit adder,
// one nibble per phase, least-significant slice first, with a start/done handshake.
module wide_add_sequencer #(
    parameter int NIBBLES = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CW = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_sh, b_sh;
    logic            a_msb, b_msb;
    logic            accept, phase_end, last_slice;

    always_comb begin
        accept     = start && (state != RUN);
        phase_end  = (state == RUN) && (cnt == CW'(ADD_LAT));
        last_slice = (idx == IW'(NIBBLES - 1));
        busy       = (state == RUN);
        done       = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (phase_end && last_slice) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are kept pre-shifted so the next slice is always in the low nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (accept) begin
            a_sh    <= a >> 4;
            b_sh    <= b >> 4;
            a_msb   <= a[W-1];
            b_msb   <= b[W-1];
            add_a   <= a[3:0];
            add_b   <= b[3:0];
            add_cin <= cin;
            idx     <= '0;
            cnt     <= '0;
        end else if (state == RUN) begin
            if (!phase_end) begin
                cnt <= cnt + CW'(1);
            end else begin
                for (int unsigned s = 0; s < NIBBLES; s++) begin
                    if (idx == IW'(s)) result[4*s +: 4] <= add_sum;
                end
                if (last_slice) begin
                    cout    <= add_cout;
                    ovf     <= (a_msb == b_msb) && (add_sum[3] != a_msb);
                    add_a   <= '0;
                    add_b   <= '0;
                    add_cin <= 1'b0;
                end else begin
                    idx     <= idx + IW'(1);
                    cnt     <= '0;
                    add_a   <= a_sh[3:0];
                    add_b   <= b_sh[3:0];
                    add_cin <= add_cout;
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                end
            end
        end else begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: 16-bit sequencer driving a behavioural 2-edge registered adder,
// compared against plain-arithmetic expectations.
module tb_wide_add_sequencer;

    localparam int NIB = 4;
    localparam int LAT = 2;
    localparam int W   = 4 * NIB;
    localparam int PH  = LAT + 1;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;

    logic [4:0]   p1 = '0, p2 = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.NIBBLES(NIB), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // Attached adder: output valid two edges after its inputs settle.
    always @(posedge clk) begin
        p1 <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
        p2 <= p1;
    end
    assign add_sum  = p2[3:0];
    assign add_cout = p2[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept edge: present operands with start at a negedge, return after the posedge.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accepting edge. poke_k: cycle in RUN to pulse start with junk.
    // hold: from the last RUN cycle keep start high with (na,nb,0) so DONE re-accepts.
    task automatic track(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int poke_k, input bit hold,
                         input logic [W-1:0] na, input logic [W-1:0] nb);
        longint unsigned sum, mask, cexp;
        int k, busy_cnt, done_k, s;
        bit both;
        sum = longint'(ta) + longint'(tb) + longint'(tc);
        busy_cnt = 0; done_k = 0; both = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (k == poke_k) start = 1'b1;
            if (hold && k >= NIB*PH) begin
                start = 1'b1; a = na; b = nb; cin = 1'b0;
            end
            if (busy && done) both = 1;
            if (busy) begin
                busy_cnt++;
                s = (k - 1) / PH;
                mask = (64'd1 << (4*s)) - 1;
                cexp = (s == 0) ? longint'(tc)
                     : ((longint'(ta) & mask) + (longint'(tb) & mask) + longint'(tc)) >> (4*s);
                check("add_a", 32'(add_a), 32'((ta >> (4*s)) & 16'hF));
                check("add_b", 32'(add_b), 32'((tb >> (4*s)) & 16'hF));
                check("add_cin", 32'(add_cin), 32'(cexp & 1));
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        check("done_latency", done_k, NIB*PH + 1);
        check("busy_cycles", busy_cnt, NIB*PH);
        check("busy_done_overlap", 32'(both), 0);
        check("result", 32'(result), 32'(sum[W-1:0]));
        check("cout", 32'(cout), 32'(sum[W]));
        check("ovf", 32'(ovf), 32'((ta[W-1] == tb[W-1]) && (sum[W-1] != ta[W-1])));
        check("done_add_zero", {add_a, add_b, 3'b0, add_cin}, 0);
        if (!hold) begin
            @(negedge clk);
            check("done_one_cycle", {30'b0, done, busy}, 0);
            check("result_held", 32'(result), 32'(sum[W-1:0]));
            check("idle_add_zero", {add_a, add_b, 3'b0, add_cin}, 0);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, done, cout, ovf, add_a, add_b, add_cin}, 0);
        check("reset_result", 32'(result), 0);
        rst = 1'b0;

        launch(16'h1234, 16'h4321, 1'b0); track(16'h1234, 16'h4321, 1'b0, 0, 0, 0, 0);
        launch(16'hFFFF, 16'h0001, 1'b0); track(16'hFFFF, 16'h0001, 1'b0, 0, 0, 0, 0);
        launch(16'h7FFF, 16'h0000, 1'b1); track(16'h7FFF, 16'h0000, 1'b1, 0, 0, 0, 0);
        launch(16'h8000, 16'h8000, 1'b0); track(16'h8000, 16'h8000, 1'b0, 0, 0, 0, 0);

        // start pulsed mid-RUN is ignored
        launch(16'h1234, 16'h4321, 1'b0); track(16'h1234, 16'h4321, 1'b0, 5, 0, 0, 0);

        // start held through DONE: back-to-back acceptance
        launch(16'h0F0F, 16'h1111, 1'b1); track(16'h0F0F, 16'h1111, 1'b1, 0, 1, 16'h0001, 16'h0002);
        @(posedge clk);
        track(16'h0001, 16'h0002, 1'b0, 0, 0, 0, 0);

        // reset during slice 2 aborts without a done pulse
        launch(16'hABCD, 16'h1357, 1'b0);
        for (int k = 1; k <= 2*PH + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_flags", {busy, done, cout, ovf}, 0);
        check("abort_result", 32'(result), 0);
        check("abort_add", {add_a, add_b, 3'b0, add_cin}, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("abort_no_done", 32'(seen), 0);
        launch(16'hAAAA, 16'h5555, 1'b0); track(16'hAAAA, 16'h5555, 1'b0, 0, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            launch(ra, rb, rc);
            track(ra, rb, rc, (n % 3 == 0) ? int'($urandom_range(1, NIB*PH - 1)) : 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
